// File: rtl/pool_pkg.sv
// Shared types and constants for the average-pooling controller.
package pool_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StAccWait,
      StDivIssue,
      StDivWait,
      StOut
   } state_e;

   localparam logic [15:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/pool_wdog.sv
// Response watchdog: counts wait cycles and flags when WAIT_MAX elapse without an answer.
module pool_wdog #(
   parameter int unsigned WAIT_MAX = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Fires in the WAIT_MAX-th enabled cycle after the last clear.
   assign expired = enable && !clear && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pool_ctrl.sv
// Average-pooling sequencer: streams window elements through the sacc unit, then issues one divide.
module pool_ctrl
   import pool_pkg::*;
#(
   parameter int unsigned CNT_W    = 9,
   parameter int unsigned WAIT_MAX = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      acc_tmp_sum,
   output logic [15:0]      acc_data,
   output logic             acc_data_ready,
   output logic             acc_div_en,
   input  logic             acc_pool_ready,
   input  logic [15:0]      acc_result,
   input  logic [15:0]      acc_result_div,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [15:0]      sum_q, sum_d;
   logic [15:0]      out_data_q, out_data_d;
   logic [15:0]      acc_data_q, acc_data_d;
   logic [15:0]      acc_tmp_sum_q, acc_tmp_sum_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             strobe_q, strobe_d;
   logic             wd_clear, wd_en, wd_expired;

   assign wd_en = (state_q == StAccWait) || (state_q == StDivWait);

   pool_wdog #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_en),
      .expired (wd_expired)
   );

   always_comb begin
      state_d       = state_q;
      remain_d      = remain_q;
      sum_d         = sum_q;
      out_data_d    = out_data_q;
      acc_data_d    = acc_data_q;
      acc_tmp_sum_d = acc_tmp_sum_q;
      err_d         = err_q;
      done_d        = 1'b0;
      strobe_d      = 1'b0;
      wd_clear      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (cfg_count != '0) begin
                  remain_d = cfg_count;
                  sum_d    = FP16_ZERO;
                  err_d    = 1'b0;
                  state_d  = StFetch;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StFetch: begin
            if (in_valid) begin
               acc_data_d    = in_data;
               acc_tmp_sum_d = sum_q;
               strobe_d      = 1'b1;
               remain_d      = remain_q - 1'b1;
               wd_clear      = 1'b1;
               state_d       = StAccWait;
            end
         end
         StAccWait: begin
            // A response wins over a same-cycle timeout.
            if (acc_pool_ready) begin
               sum_d   = acc_result;
               state_d = (remain_q != '0) ? StFetch : StDivIssue;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StDivIssue: begin
            acc_tmp_sum_d = sum_q;
            strobe_d      = 1'b1;
            wd_clear      = 1'b1;
            state_d       = StDivWait;
         end
         StDivWait: begin
            if (acc_pool_ready) begin
               out_data_d = acc_result_div;
               state_d    = StOut;
            end else if (wd_expired) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         StOut: begin
            if (out_ready) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         remain_q      <= '0;
         sum_q         <= FP16_ZERO;
         out_data_q    <= FP16_ZERO;
         acc_data_q    <= FP16_ZERO;
         acc_tmp_sum_q <= FP16_ZERO;
         err_q         <= 1'b0;
         done_q        <= 1'b0;
         strobe_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         remain_q      <= remain_d;
         sum_q         <= sum_d;
         out_data_q    <= out_data_d;
         acc_data_q    <= acc_data_d;
         acc_tmp_sum_q <= acc_tmp_sum_d;
         err_q         <= err_d;
         done_q        <= done_d;
         strobe_q      <= strobe_d;
      end
   end

   assign busy           = (state_q != StIdle);
   assign in_ready       = (state_q == StFetch);
   assign out_valid      = (state_q == StOut);
   assign acc_div_en     = (state_q == StDivIssue) || (state_q == StDivWait);
   assign done           = done_q;
   assign err            = err_q;
   assign acc_data_ready = strobe_q;
   assign acc_data       = acc_data_q;
   assign acc_tmp_sum    = acc_tmp_sum_q;
   assign out_data       = out_data_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with a small fixed-latency sacc model driving 1.0-valued elements.
module tb_pool_ctrl;

   localparam int unsigned CNT_W    = 9;
   localparam int unsigned WAIT_MAX = 64;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] cfg_count = '0;
   logic             busy, done, err, in_ready;
   logic [15:0]      in_data = 16'h0000;
   logic             in_valid = 1'b0;
   logic [15:0]      acc_tmp_sum, acc_data, out_data;
   logic             acc_data_ready, acc_div_en, out_valid;
   logic             acc_pool_ready;
   logic [15:0]      acc_result;
   logic [15:0]      acc_result_div = 16'h0000;
   logic             out_ready = 1'b0;

   logic             model_on = 1'b1;
   logic             model_rdy = 1'b0;
   logic [15:0]      model_result = 16'h0000;
   logic             spur_rdy = 1'b0;
   logic [15:0]      div_code = 16'h3c00;

   assign acc_pool_ready = model_rdy | spur_rdy;
   assign acc_result     = spur_rdy ? 16'h7bff : model_result;

   int n_tests = 0;
   int n_fail = 0;
   int done_cnt = 0;
   logic [15:0] iss_sum[$];
   logic        iss_div[$];
   logic [15:0] iss_data[$];

   always #5 clk = ~clk;

   pool_ctrl #(
      .CNT_W    (CNT_W),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cfg_count      (cfg_count),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .acc_tmp_sum    (acc_tmp_sum),
      .acc_data       (acc_data),
      .acc_data_ready (acc_data_ready),
      .acc_div_en     (acc_div_en),
      .acc_pool_ready (acc_pool_ready),
      .acc_result     (acc_result),
      .acc_result_div (acc_result_div),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready)
   );

   function automatic int fp_to_int(input logic [15:0] f);
      case (f)
         16'h0000: return 0;
         16'h3c00: return 1;
         16'h4000: return 2;
         16'h4200: return 3;
         16'h4400: return 4;
         16'h4500: return 5;
         16'h4600: return 6;
         default:  return 100;
      endcase
   endfunction

   function automatic logic [15:0] int_to_fp(input int v);
      case (v)
         0:       return 16'h0000;
         1:       return 16'h3c00;
         2:       return 16'h4000;
         3:       return 16'h4200;
         4:       return 16'h4400;
         5:       return 16'h4500;
         6:       return 16'h4600;
         default: return 16'hffff;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctrl"}, {busy, done, err, in_ready, out_valid, acc_data_ready, acc_div_en}, 0);
      check({tag, "_out_data"}, out_data, 16'h0000);
      check({tag, "_acc_data"}, acc_data, 16'h0000);
      check({tag, "_acc_tmp_sum"}, acc_tmp_sum, 16'h0000);
   endtask

   // Every element is 1.0, so issue i carries the fp16 for i; the divide issue carries c.
   task automatic check_window(input string tag, input int c);
      check({tag, "_n_issues"}, iss_sum.size(), c + 1);
      for (int i = 0; i <= c && i < iss_sum.size(); i++) begin
         check({tag, "_tmp_sum"}, iss_sum[i], int_to_fp(i));
         check({tag, "_div_en"}, iss_div[i], (i == c));
         if (i < c) check({tag, "_acc_data"}, iss_data[i], 16'h3c00);
      end
   endtask

   task automatic clear_log();
      iss_sum.delete();
      iss_div.delete();
      iss_data.delete();
   endtask

   task automatic pulse_start(input logic [CNT_W-1:0] cnt);
      @(posedge clk); #1;
      cfg_count = cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < bound) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, seen, 1'b1);
   endtask

   task automatic wait_strobe(input string tag, input logic want_div);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (acc_data_ready && (acc_div_en == want_div)) seen = 1'b1;
      end
      check({tag, "_strobe_seen"}, seen, 1'b1);
   endtask

   // sacc model: answers each issue after a fixed delay.
   initial begin
      logic [15:0] t, d;
      forever begin
         @(posedge clk); #1;
         if (acc_data_ready && model_on) begin
            t = acc_tmp_sum;
            d = acc_data;
            repeat (3) @(posedge clk);
            #1;
            model_result   = int_to_fp(fp_to_int(t) + fp_to_int(d));
            acc_result_div = div_code;
            model_rdy      = 1'b1;
            @(posedge clk); #1;
            model_rdy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (acc_data_ready) begin
            iss_sum.push_back(acc_tmp_sum);
            iss_div.push_back(acc_div_en);
            iss_data.push_back(acc_data);
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "bench timeout");
   end

   initial begin
      int d0, n;
      int gaps[3];
      logic seen;
      gaps = '{0, 4, 2};

      // Reset state
      #1 rst_n = 1'b0;
      #11;
      check_reset_state("rst");
      @(negedge clk) rst_n = 1'b1;

      // Four 1.0 elements, divide, back-pressured output
      clear_log();
      in_data  = 16'h3c00;
      in_valid = 1'b1;
      out_ready = 1'b0;
      div_code = 16'h3c00;
      pulse_start(4);
      n = 0;
      while (!out_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("t1_out_valid_seen", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("t1_hold_valid", out_valid, 1'b1);
         check("t1_hold_data", out_data, 16'h3c00);
         if (i < 4) begin
            @(posedge clk); #1;
         end
      end
      check("t1_div_en_in_out", acc_div_en, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t1_done", done, 1'b1);
      check("t1_idle", {busy, out_valid}, 2'b00);
      @(posedge clk); #1;
      check("t1_done_one_cycle", done, 1'b0);
      check_window("t1", 4);

      // Timeout with a silent sacc, then err clears on the next start
      clear_log();
      model_on = 1'b0;
      in_valid = 1'b1;
      pulse_start(2);
      wait_strobe("t2", 1'b0);
      n = 0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("t2_timeout_cycles", n, WAIT_MAX);
      check("t2_err", err, 1'b1);
      check("t2_idle", {busy, acc_div_en}, 2'b00);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("t2_err_sticky", {err, done}, 2'b10);
      check("t2_one_issue", iss_sum.size(), 1);
      model_on  = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      pulse_start(1);
      check("t2_err_cleared", err, 1'b0);
      wait_done("t2_rerun", 100);
      check("t2_rerun_err", err, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);

      // Input gaps and a spurious acc_pool_ready while fetching
      #1;
      clear_log();
      d0 = done_cnt;
      pulse_start(3);
      for (int k = 0; k < 3; k++) begin
         seen = 1'b0;
         n = 0;
         while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (in_ready) seen = 1'b1;
         end
         check("t3_fetch_seen", seen, 1'b1);
         for (int g = 0; g < gaps[k]; g++) begin
            spur_rdy = (k == 1) && (g == 0);
            @(negedge clk);
         end
         spur_rdy = 1'b0;
         in_data  = 16'h3c00;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
      end
      wait_done("t3", 200);
      repeat (3) @(posedge clk);
      #1;
      check_window("t3", 3);
      check("t3_done_count", done_cnt - d0, 1);

      // Reset while waiting on an accumulate
      clear_log();
      d0 = done_cnt;
      in_valid = 1'b1;
      pulse_start(3);
      wait_strobe("t4", 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_state("t4_async");
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("t4_no_done", done_cnt - d0, 0);
      rst_n = 1'b1;
      clear_log();
      d0 = done_cnt;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      pulse_start(2);
      wait_done("t4_rerun", 200);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_window("t4_rerun", 2);
      check("t4_rerun_done_count", done_cnt - d0, 1);

      // start during DIV_WAIT is ignored; zero-count start only pulses done
      clear_log();
      d0 = done_cnt;
      in_valid = 1'b1;
      pulse_start(2);
      wait_strobe("t5_div", 1'b1);
      cfg_count = 9'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t5_still_div_wait", {busy, acc_div_en}, 2'b11);
      wait_done("t5", 100);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t5_no_restart", busy, 1'b0);
      check_window("t5", 2);
      check("t5_done_count", done_cnt - d0, 1);
      clear_log();
      d0 = done_cnt;
      pulse_start(0);
      check("t5_zero_done", {done, busy}, 2'b10);
      repeat (4) @(posedge clk);
      #1;
      check("t5_zero_no_issue", iss_sum.size(), 0);
      check("t5_zero_done_count", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter CNT_W, default 9, width of window-element count.
REQ-002 Parameter WAIT_MAX, default 64, max cycles to wait for a sacc response before error.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to pool one window; ignored unless IDLE.
REQ-006 cfg_count  in  CNT_W  elements per window, sampled on accepted start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse when a window completes or aborts.
REQ-009 err  out  1  sticky timeout flag; cleared on next accepted start.
REQ-010 in_data  in  16  fp16 input element.
REQ-011 in_valid  in  1  input element available.
REQ-012 in_ready  out  1  controller accepts element this cycle.
REQ-013 acc_tmp_sum  out  16  running fp16 sum to sacc tmp_sum.
REQ-014 acc_data  out  16  element to sacc data.
REQ-015 acc_data_ready  out  1  one-cycle issue strobe to sacc data_ready.
REQ-016 acc_div_en  out  1  selects divide path in sacc.
REQ-017 acc_pool_ready  in  1  sacc completion pulse.
REQ-018 acc_result  in  16  sacc accumulate result.
REQ-019 acc_result_div  in  16  sacc divide result.
REQ-020 out_data  out  16  pooled fp16 average.
REQ-021 out_valid  out  1  out_data valid; held until out_ready.
REQ-022 out_ready  in  1  downstream accepts out_data.

Function
REQ-023 States SHALL be IDLE, FETCH, ACC_WAIT, DIV_ISSUE, DIV_WAIT, OUT.
REQ-024 IDLE: start with cfg_count!=0 latches count into remain, clears sum to 16'h0000, clears err, goes FETCH; start with cfg_count==0 gives done pulse only, stays IDLE.
REQ-025 FETCH: in_ready=1; on in_valid drive acc_data=in_data, acc_tmp_sum=sum, pulse acc_data_ready one cycle, decrement remain, go ACC_WAIT.
REQ-026 ACC_WAIT: on acc_pool_ready capture acc_result into sum; remain!=0 -> FETCH, remain==0 -> DIV_ISSUE.
REQ-027 DIV_ISSUE: acc_div_en=1, acc_tmp_sum=sum, pulse acc_data_ready one cycle, go DIV_WAIT.
REQ-028 acc_div_en SHALL stay 1 through DIV_WAIT until the capture cycle, 0 in all other states.
REQ-029 DIV_WAIT: on acc_pool_ready capture acc_result_div into out_data, go OUT.
REQ-030 OUT: out_valid=1, out_data stable; on out_ready pulse done, go IDLE.
REQ-031 acc_pool_ready SHALL be ignored outside ACC_WAIT/DIV_WAIT.
REQ-032 acc_tmp_sum and acc_data SHALL be registered and stable from the issue cycle until the next issue.
REQ-033 Wait counter resets on entry to ACC_WAIT/DIV_WAIT; reaching WAIT_MAX without acc_pool_ready sets err, pulses done, returns IDLE, drops acc_div_en.
REQ-034 in_ready SHALL be 0 outside FETCH; no element accepted while a sacc operation is outstanding.
REQ-035 start while busy SHALL have no effect.
REQ-036 Pipeline: one element per issue/response round trip; throughput limited by sacc latency.

Reset
REQ-037 rst_n low at any time SHALL immediately force IDLE; remain=0, sum=0, out_data=0, busy/done/err/in_ready/out_valid/acc_data_ready/acc_div_en=0, acc_data=acc_tmp_sum=0.
REQ-038 A window interrupted by reset is discarded; no done pulse.

Structure
REQ-039 Package pool_pkg SHALL hold the state enumeration and FP16_ZERO = 16'h0000.
REQ-040 One sub-module, pool_wdog, SHALL implement the WAIT_MAX timeout counter (clear, enable, expired).
REQ-041 No arithmetic in pool_ctrl; all fp16 math in sacc.

Verification
REQ-042 cfg_count=4, inputs 0x3c00 x4, sacc model latency 3 -> acc_tmp_sum issues 0x0000,0x3c00,0x4000,0x4200; divide issue with acc_tmp_sum=0x4400 and acc_div_en=1.
REQ-043 Same run, model returns acc_result_div=0x3c00, out_ready low 5 cycles -> out_valid/out_data=0x3c00 held 5 cycles, done one cycle after out_ready.
REQ-044 cfg_count=2, model never answers -> err=1 and done pulse WAIT_MAX cycles after issue; next start clears err.
REQ-045 in_valid gaps of 0-4 cycles, spurious acc_pool_ready in FETCH -> exactly cfg_count issues, sum unaffected by spurious pulse.
REQ-046 rst_n low in ACC_WAIT -> all outputs 0 asynchronously, IDLE, no done; new start runs clean.
REQ-047 start pulsed during DIV_WAIT and cfg_count=0 start in IDLE -> first ignored; second gives done, no acc_data_ready.
